// File: rtl/smi_frame_scheduler_x4_pkg.sv
// Shared constants, state encoding and the round-robin pick used by the
// four-port SMI frame scheduler.
package smi_frame_scheduler_x4_pkg;

  localparam int unsigned NumPorts = 4;
  localparam int unsigned PortIdxW = 2;

  typedef logic [PortIdxW-1:0] port_idx_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  typedef struct packed {
    logic      valid;
    port_idx_t idx;
  } rr_pick_t;

  // First requesting port at or after start, wrapping modulo NumPorts.
  function automatic rr_pick_t rr_pick(input logic [NumPorts-1:0] req,
                                       input port_idx_t start);
    rr_pick_t  res;
    port_idx_t idx;
    res = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      idx = start + port_idx_t'(i);
      if (!res.valid && req[idx]) begin
        res.valid = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  // Frame quota for a port; a programmed weight of zero still grants one frame.
  function automatic logic [3:0] weight_of(input logic [15:0] weights,
                                           input port_idx_t   port);
    logic [3:0] w;
    w = weights[{port, 2'b00} +: 4];
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

endpackage

// File: rtl/smi_frame_scheduler_x4_dbuf.sv
// Two-entry self-link buffer: full throughput, with the upstream stop taken
// from a register so it never depends combinationally on the downstream stop.
module smiSelfLinkDoubleBuffer #(
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_stop_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_stop_i
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;

  assign in_stop_o   = skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (!main_v_q || !out_stop_i) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_valid_i;
        if (in_valid_i) main_d = in_data_i;
      end
    end else if (in_valid_i && !skid_v_q) begin
      // Flit already committed upstream while the head is stalled: park it.
      skid_v_d = 1'b1;
      skid_d   = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/smi_frame_scheduler_x4.sv
// Four-port SMI frame scheduler: per-port input slices, weighted round-robin
// grant at frame boundaries, and a double-buffered output link.
module smi_frame_scheduler_x4
  import smi_frame_scheduler_x4_pkg::*;
#(
  parameter int unsigned FlitWidth = 2,
  parameter logic [7:0]  EofcMask  = 8'(2*FlitWidth-1)
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [3:0]                 smiInReady,
  input  logic [31:0]                smiInEofc,
  input  logic [4*FlitWidth*8-1:0]   smiInData,
  output logic [3:0]                 smiInStop,
  input  logic [15:0]                cfgWeight,
  output logic                       smiOutReady,
  output logic [7:0]                 smiOutEofc,
  output logic [FlitWidth*8-1:0]     smiOutData,
  input  logic                       smiOutStop,
  output logic                       grantValid,
  output logic [1:0]                 grantPort
);

  localparam int unsigned DataW = FlitWidth*8;
  localparam int unsigned BufW  = (FlitWidth+1)*8;

  logic [NumPorts-1:0] ready_q, ready_d, last_q, halt;
  logic [7:0]          eofc_q [NumPorts];
  logic [DataW-1:0]    data_q [NumPorts];

  logic [0:0]          state_q, state_d;
  port_idx_t           grant_q, grant_d, rr_q, rr_d;
  logic [3:0]          quota_q, quota_d, quota_dec;
  logic [NumPorts-1:0] others;
  rr_pick_t            pick_any, pick_next;

  logic                buf_stop, xfer;
  logic [BufW-1:0]     buf_out;

  always_comb begin
    for (int unsigned n = 0; n < NumPorts; n++) begin
      halt[n] = 1'b1;
      if (state_q == ST_XFER && grant_q == port_idx_t'(n)) halt[n] = buf_stop;
    end
  end

  assign smiInStop = ready_q & halt;
  // Slice contents as of the next edge; arbitration looks at this so a grant
  // lands exactly when the chosen port's flit is sitting in its slice.
  assign ready_d   = (ready_q & smiInStop) | (smiInReady & ~smiInStop);

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < NumPorts; n++) begin
      if (srst) begin
        ready_q[n] <= 1'b0;
        last_q[n]  <= 1'b0;
        eofc_q[n]  <= '0;
        data_q[n]  <= '0;
      end else if (!smiInStop[n]) begin
        ready_q[n] <= smiInReady[n];
        last_q[n]  <= (smiInEofc[8*n +: 8] != 8'd0);
        eofc_q[n]  <= smiInEofc[8*n +: 8] & EofcMask;
        data_q[n]  <= smiInData[DataW*n +: DataW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    quota_d   = quota_q;
    xfer      = 1'b0;
    quota_dec = quota_q - 4'd1;
    others    = ready_d;
    others[grant_q] = 1'b0;
    pick_any  = rr_pick(ready_d, rr_q);
    pick_next = rr_pick(others, grant_q + 2'd1);
    case (state_q)
      ST_IDLE: begin
        if (pick_any.valid) begin
          state_d = ST_XFER;
          grant_d = pick_any.idx;
          quota_d = weight_of(cfgWeight, pick_any.idx);
        end
      end
      ST_XFER: begin
        xfer = ready_q[grant_q] & ~buf_stop;
        if (xfer && last_q[grant_q]) begin
          quota_d = quota_dec;
          if (quota_dec == 4'd0 || !ready_d[grant_q]) begin
            rr_d = grant_q + 2'd1;
            if (pick_next.valid) begin
              grant_d = pick_next.idx;
              quota_d = weight_of(cfgWeight, pick_next.idx);
            end else if (ready_d[grant_q]) begin
              quota_d = weight_of(cfgWeight, grant_q);
            end else begin
              state_d = ST_IDLE;
              quota_d = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      quota_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      quota_q <= quota_d;
    end
  end

  smiSelfLinkDoubleBuffer #(
    .Width(BufW)
  ) u_out_buf (
    .clk        (clk),
    .srst       (srst),
    .in_valid_i (xfer),
    .in_data_i  ({eofc_q[grant_q], data_q[grant_q]}),
    .in_stop_o  (buf_stop),
    .out_valid_o(smiOutReady),
    .out_data_o (buf_out),
    .out_stop_i (smiOutStop)
  );

  assign smiOutEofc = buf_out[BufW-1 -: 8];
  assign smiOutData = buf_out[DataW-1:0];
  assign grantValid = (state_q == ST_XFER);
  assign grantPort  = grant_q;

endmodule

// File: tb/tb_smi_frame_scheduler_x4.sv
// Scoreboard bench for smi_frame_scheduler_x4: sources stream queued frames,
// a frame-level weighted round-robin model predicts the output flit order.
module tb_smi_frame_scheduler_x4;

  localparam int FW = 2;
  localparam int DW = FW*8;
  localparam logic [7:0] MASK = 8'(2*FW-1);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [7:0]    e;
  } flit_t;

  logic          clk = 1'b0;
  logic          srst;
  logic [3:0]    smiInReady;
  logic [31:0]   smiInEofc;
  logic [4*DW-1:0] smiInData;
  logic [3:0]    smiInStop;
  logic [15:0]   cfgWeight;
  logic          smiOutReady;
  logic [7:0]    smiOutEofc;
  logic [DW-1:0] smiOutData;
  logic          smiOutStop;
  logic          grantValid;
  logic [1:0]    grantPort;

  always #5 clk = ~clk;

  smi_frame_scheduler_x4 #(.FlitWidth(FW)) dut (
    .clk        (clk),
    .srst       (srst),
    .smiInReady (smiInReady),
    .smiInEofc  (smiInEofc),
    .smiInData  (smiInData),
    .smiInStop  (smiInStop),
    .cfgWeight  (cfgWeight),
    .smiOutReady(smiOutReady),
    .smiOutEofc (smiOutEofc),
    .smiOutData (smiOutData),
    .smiOutStop (smiOutStop),
    .grantValid (grantValid),
    .grantPort  (grantPort)
  );

  flit_t srcq [4][$];
  int    flen [4][$];
  flit_t expq [$];

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    stall_pct = 0;
  bit    force_stop = 1'b0;
  logic [3:0] stop_seen = '0;
  int    out_cnt = 0;
  int    first_out = 0;
  int    last_out = 0;
  flit_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit srcs_left();
    return (srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()) > 0;
  endfunction

  // One clock: retire flits the DUT accepted, present the next ones, pick the stall.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int p = 0; p < 4; p++)
      if (smiInReady[p] && !stop_seen[p] && !srst && srcq[p].size() > 0)
        void'(srcq[p].pop_front());
    for (int p = 0; p < 4; p++) begin
      if (!srst && srcq[p].size() > 0) begin
        smiInReady[p]          = 1'b1;
        smiInData[p*DW +: DW]  = srcq[p][0].d;
        smiInEofc[p*8 +: 8]    = srcq[p][0].e;
      end else begin
        smiInReady[p]          = 1'b0;
        smiInData[p*DW +: DW]  = '0;
        smiInEofc[p*8 +: 8]    = '0;
      end
    end
    smiOutStop = force_stop || ($urandom_range(0, 99) < stall_pct);
    stop_seen  = smiInStop;
  endtask

  always @(negedge clk) begin
    #2;
    if (!srst && smiOutReady && !smiOutStop) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got data=%0h eofc=%0h, required no flit", smiOutData, smiOutEofc);
      end else begin
        mon_e = expq.pop_front();
        if (smiOutData !== mon_e.d || smiOutEofc !== mon_e.e) begin
          failures++;
          $display("FAIL out_flit: got data=%0h eofc=%0h, required data=%0h eofc=%0h",
                   smiOutData, smiOutEofc, mon_e.d, mon_e.e);
        end
      end
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
    end
  end

  task automatic add_frame(input int p, input int len, input logic [7:0] last_e);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.d = DW'($urandom);
      f.d[DW-1 -: 2] = 2'(p);
      f.e = (k == len-1) ? last_e : 8'd0;
      srcq[p].push_back(f);
    end
    flen[p].push_back(len);
  endtask

  function automatic int wload(input logic [15:0] w, input int p);
    int v;
    v = int'((w >> (4*p)) & 16'hF);
    return (v == 0) ? 1 : v;
  endfunction

  // Frame-level weighted round robin; a port counts as ready whenever it
  // still has frames queued (sources stream back to back).
  task automatic build_expect(input logic [15:0] wf, input logic [15:0] wl);
    int lens [4][$];
    int pos [4];
    int cur, rr, quota, n, nxt, idx;
    bit first;
    flit_t f;
    for (int p = 0; p < 4; p++) begin
      lens[p] = flen[p];
      pos[p]  = 0;
    end
    cur = -1; rr = 0; quota = 0; first = 1'b1;
    while (lens[0].size() + lens[1].size() + lens[2].size() + lens[3].size() > 0) begin
      if (cur < 0) begin
        for (int i = 0; i < 4; i++) begin
          idx = (rr + i) % 4;
          if (cur < 0 && lens[idx].size() > 0) cur = idx;
        end
        quota = wload(first ? wf : wl, cur);
        first = 1'b0;
      end
      n = lens[cur].pop_front();
      for (int k = 0; k < n; k++) begin
        f = srcq[cur][pos[cur]];
        pos[cur]++;
        f.e = f.e & MASK;
        expq.push_back(f);
      end
      quota--;
      if (!(quota > 0 && lens[cur].size() > 0)) begin
        rr  = (cur + 1) % 4;
        nxt = -1;
        for (int i = 0; i < 4; i++) begin
          idx = (rr + i) % 4;
          if (nxt < 0 && idx != cur && lens[idx].size() > 0) nxt = idx;
        end
        if (nxt < 0 && lens[cur].size() > 0) nxt = cur;
        cur = nxt;
        if (cur >= 0) quota = wload(wl, cur);
      end
    end
  endtask

  task automatic do_reset();
    for (int p = 0; p < 4; p++) begin
      srcq[p].delete();
      flen[p].delete();
    end
    expq.delete();
    force_stop = 1'b0;
    stall_pct  = 0;
    srst = 1'b1;
    step();
    step();
    chk("rst_out_ready", 32'(smiOutReady), 0);
    chk("rst_in_stop", 32'(smiInStop), 0);
    chk("rst_grant_valid", 32'(grantValid), 0);
    chk("rst_grant_port", 32'(grantPort), 0);
    srst = 1'b0;
    step();
    chk("post_rst_out_ready", 32'(smiOutReady), 0);
    chk("post_rst_in_stop", 32'(smiInStop), 0);
    out_cnt = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((expq.size() > 0 || srcs_left()) && n < budget) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    if (expq.size() > 0 || srcs_left()) begin
      failures++;
      $display("FAIL %s_drain: %0d flits outstanding after %0d cycles, required 0", name, expq.size(), budget);
    end
  endtask

  initial begin
    int c0, total, nfr, len, n;
    logic [15:0] w;
    srst = 1'b1; smiInReady = '0; smiInEofc = '0; smiInData = '0;
    smiOutStop = 1'b0; cfgWeight = 16'h1111;

    // Single port, 3-flit frame: latency, grant and eofc on the last flit
    do_reset();
    add_frame(2, 3, 8'd2);
    build_expect(cfgWeight, cfgWeight);
    step();
    c0 = cyc;
    step();
    chk("p2_grant_valid", 32'(grantValid), 1);
    chk("p2_grant_port", 32'(grantPort), 2);
    drain("p2", 50);
    chk("p2_latency", 32'(first_out - c0), 2);
    chk("p2_count", 32'(out_cnt), 3);

    // All ports ready, weight 1, one-flit frames: strict rotation, no gaps
    do_reset();
    cfgWeight = 16'h1111;
    for (int r = 0; r < 6; r++)
      for (int p = 0; p < 4; p++) add_frame(p, 1, 8'($urandom_range(1, 255)));
    build_expect(cfgWeight, cfgWeight);
    drain("rr", 200);
    chk("rr_span", 32'(last_out - first_out + 1), 24);

    // Weights 3,1,1,1
    do_reset();
    cfgWeight = 16'h1113;
    total = 0;
    for (int r = 0; r < 9; r++) begin
      len = $urandom_range(1, 2); total += len;
      add_frame(0, len, 8'($urandom_range(1, 255)));
    end
    for (int p = 1; p < 4; p++)
      for (int r = 0; r < 3; r++) begin
        len = $urandom_range(1, 2); total += len;
        add_frame(p, len, 8'($urandom_range(1, 255)));
      end
    build_expect(cfgWeight, cfgWeight);
    drain("wrr", 400);
    chk("wrr_span", 32'(last_out - first_out + 1), 32'(total));

    // Randomized weights, frame mixes and output stalls
    for (int it = 0; it < 4; it++) begin
      do_reset();
      w = 16'($urandom);
      cfgWeight = w;
      stall_pct = 30;
      for (int p = 0; p < 4; p++) begin
        nfr = $urandom_range(0, 6);
        for (int r = 0; r < nfr; r++)
          add_frame(p, $urandom_range(1, 4), 8'($urandom_range(1, 255)));
      end
      build_expect(cfgWeight, cfgWeight);
      drain("rand", 2000);
    end

    // Output stalled for 5 cycles in the middle of a frame
    do_reset();
    cfgWeight = 16'h1111;
    add_frame(1, 12, 8'd1);
    build_expect(cfgWeight, cfgWeight);
    n = 0;
    step();
    while (!smiOutReady && n < 10) begin
      step();
      n++;
    end
    chk("stall_first_out", 32'(smiOutReady), 1);
    force_stop = 1'b1;
    step();
    step();
    chk("stall_in_stop", 32'(smiInStop[1]), 1);
    chk("stall_grant_port", 32'(grantPort), 1);
    step();
    step();
    step();
    chk("stall_in_stop_held", 32'(smiInStop[1]), 1);
    force_stop = 1'b0;
    drain("stall", 100);
    chk("stall_count", 32'(out_cnt), 12);

    // Reset during the second flit of a port-1 frame
    do_reset();
    cfgWeight = 16'h1111;
    add_frame(1, 4, 8'd3);
    step();
    step();
    step();
    do_reset();
    add_frame(0, 2, 8'd1);
    add_frame(1, 2, 8'd2);
    build_expect(cfgWeight, cfgWeight);
    step();
    step();
    chk("rst_regrant_valid", 32'(grantValid), 1);
    chk("rst_regrant_port", 32'(grantPort), 0);
    drain("rst_mid", 100);

    // Port-0 weight raised 1->4 while its first frame is in flight
    do_reset();
    cfgWeight = 16'h1111;
    add_frame(0, 4, 8'd1);
    for (int r = 0; r < 5; r++) add_frame(0, 1, 8'd2);
    for (int r = 0; r < 3; r++) add_frame(1, 1, 8'd3);
    build_expect(16'h1111, 16'h1114);
    step();
    step();
    cfgWeight = 16'h1114;
    drain("wchg", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
